// File: rtl/umi_mux_lock.sv
// umi_mux_lock: N-input UMI request mux that holds the arbiter grant until EOM and
// drives one output through a 2-entry registered skid. Optional lock monitor: UMI_MUX_LOCKMON_EN.

module umi_arbiter #(
  parameter int unsigned N      = 4,
  parameter              TARGET = "DEFAULT"
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [1:0]   mode,
  input  logic [N-1:0] mask,
  input  logic [N-1:0] requests,
  output logic [N-1:0] grants
);

  logic [N-1:0] req, pri_gnt, rr_gnt, th_gnt, rr_hi, th_elig;
  logic [N-1:0] rr_above, th_served;

  function automatic logic [N-1:0] lowest(input logic [N-1:0] v);
    return v & (~v + N'(1));
  endfunction

  assign req     = requests & ~mask;
  assign pri_gnt = lowest(req);
  assign rr_hi   = req & rr_above;
  assign rr_gnt  = (|rr_hi) ? lowest(rr_hi) : pri_gnt;
  assign th_elig = req & ~th_served;
  assign th_gnt  = (|th_elig) ? lowest(th_elig) : pri_gnt;

  always_comb begin
    grants = pri_gnt;
    case (mode)
      2'b01:   grants = rr_gnt;
      2'b10:   grants = th_gnt;
      default: grants = pri_gnt;
    endcase
  end

  // Round-robin remembers channels above the last winner; thermometer remembers who was served.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rr_above  <= '0;
      th_served <= '0;
    end else if (|grants) begin
      if (mode == 2'b01) rr_above <= ~(grants | (grants - N'(1)));
      if (mode == 2'b10) th_served <= ((|th_elig) ? th_served : '0) | grants;
    end
  end

endmodule

module umi_mux_lock #(
  parameter int unsigned N           = 4,
  parameter int unsigned CW          = 32,
  parameter int unsigned AW          = 64,
  parameter int unsigned DW          = 256,
  parameter int unsigned LOCKTIMEOUT = 1024,
  parameter              TARGET      = "DEFAULT"
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      arb_mode,
  input  logic [N-1:0]    arb_mask,
  input  logic [N-1:0]    umi_in_valid,
  input  logic [N*CW-1:0] umi_in_cmd,
  input  logic [N*AW-1:0] umi_in_dstaddr,
  input  logic [N*AW-1:0] umi_in_srcaddr,
  input  logic [N*DW-1:0] umi_in_data,
  output logic [N-1:0]    umi_in_ready,
  output logic            umi_out_valid,
  output logic [CW-1:0]   umi_out_cmd,
  output logic [AW-1:0]   umi_out_dstaddr,
  output logic [AW-1:0]   umi_out_srcaddr,
  output logic [DW-1:0]   umi_out_data,
  input  logic            umi_out_ready,
  output logic            lock_err
);

  localparam int unsigned BW   = CW + 2*AW + DW;
  localparam int unsigned EOMB = 22;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  owner, owner_nxt, grants, sel, req;
  logic [1:0]    count, count_nxt;
  logic          space, accept, pop;
  logic [CW-1:0] in_cmd;
  logic [AW-1:0] in_dst, in_src;
  logic [DW-1:0] in_data;
  logic [BW-1:0] head, spare;

  assign req = umi_in_valid & {N{state == IDLE}};

  umi_arbiter #(.N(N), .TARGET(TARGET)) u_arb (
    .clk      (clk),
    .nreset   (~reset),
    .mode     (arb_mode),
    .mask     (arb_mask),
    .requests (req),
    .grants   (grants)
  );

  // Ready depends only on the skid count and the select, never on umi_out_ready.
  assign sel          = (state == IDLE) ? grants : owner;
  assign space        = (count < 2'd2);
  assign umi_in_ready = sel & {N{space & ~reset}};
  assign accept       = |(umi_in_valid & umi_in_ready);
  assign pop          = umi_out_valid & umi_out_ready;
  assign count_nxt    = count + 2'(accept) - 2'(pop);

  always_comb begin
    in_cmd  = '0;
    in_dst  = '0;
    in_src  = '0;
    in_data = '0;
    for (int i = 0; i < N; i++) begin
      if (sel[i]) begin
        in_cmd  = umi_in_cmd[i*CW +: CW];
        in_dst  = umi_in_dstaddr[i*AW +: AW];
        in_src  = umi_in_srcaddr[i*AW +: AW];
        in_data = umi_in_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    if (accept) begin
      if (state == IDLE && !in_cmd[EOMB]) begin
        state_nxt = LOCKED;
        owner_nxt = sel;
      end else if (state == LOCKED && in_cmd[EOMB]) begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  // Skid: head drives the output registers, spare catches a beat while head is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      head  <= '0;
      spare <= '0;
    end else begin
      count <= count_nxt;
      if (accept && (count == 2'd0 || (count == 2'd1 && pop)))
        head <= {in_cmd, in_dst, in_src, in_data};
      else if (pop && count == 2'd2)
        head <= spare;
      if (accept && count == 2'd1 && !pop)
        spare <= {in_cmd, in_dst, in_src, in_data};
    end
  end

  assign umi_out_valid = (count != 2'd0);
  assign {umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data} = head;

`ifdef UMI_MUX_LOCKMON_EN
  localparam int unsigned TW = $clog2(LOCKTIMEOUT + 1);

  logic [TW-1:0] idle_cnt, idle_cnt_nxt;

  // Counts locked cycles with the owner silent; flow is never affected.
  always_comb begin
    idle_cnt_nxt = '0;
    if (state == LOCKED && !(|(umi_in_valid & owner)))
      idle_cnt_nxt = (idle_cnt == TW'(LOCKTIMEOUT)) ? idle_cnt : idle_cnt + TW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
      lock_err <= 1'b0;
    end else begin
      idle_cnt <= idle_cnt_nxt;
      if (idle_cnt_nxt == TW'(LOCKTIMEOUT)) lock_err <= 1'b1;
    end
  end
`else
  assign lock_err = 1'b0;
`endif

endmodule

// File: tb/tb_umi_mux_lock.sv
// Self-checking bench for umi_mux_lock: randomized sources against a scoreboard
// of per-channel message queues, a 2-deep output FIFO model and a lock tracker.

module tb_umi_mux_lock;

  localparam int N    = 4;
  localparam int CW   = 32;
  localparam int AW   = 64;
  localparam int DW   = 256;
  localparam int LT   = 8;
  localparam int BW   = CW + 2*AW + DW;
  localparam int EOMB = DW + 2*AW + 22;
  localparam int HIST = 64;
`ifdef UMI_MUX_LOCKMON_EN
  localparam bit LOCKMON = 1'b1;
`else
  localparam bit LOCKMON = 1'b0;
`endif

  typedef logic [BW-1:0] beat_t;
  typedef struct { int cyc; int ch; int idx; bit eom; } ev_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      arb_mode;
  logic [N-1:0]    arb_mask;
  logic [N-1:0]    umi_in_valid;
  logic [N*CW-1:0] umi_in_cmd;
  logic [N*AW-1:0] umi_in_dstaddr;
  logic [N*AW-1:0] umi_in_srcaddr;
  logic [N*DW-1:0] umi_in_data;
  logic [N-1:0]    umi_in_ready;
  logic            umi_out_valid;
  logic [CW-1:0]   umi_out_cmd;
  logic [AW-1:0]   umi_out_dstaddr;
  logic [AW-1:0]   umi_out_srcaddr;
  logic [DW-1:0]   umi_out_data;
  logic            umi_out_ready;
  logic            lock_err;

  umi_mux_lock #(.N(N), .CW(CW), .AW(AW), .DW(DW), .LOCKTIMEOUT(LT), .TARGET("DEFAULT")) dut (
    .clk             (clk),
    .reset           (reset),
    .arb_mode        (arb_mode),
    .arb_mask        (arb_mask),
    .umi_in_valid    (umi_in_valid),
    .umi_in_cmd      (umi_in_cmd),
    .umi_in_dstaddr  (umi_in_dstaddr),
    .umi_in_srcaddr  (umi_in_srcaddr),
    .umi_in_data     (umi_in_data),
    .umi_in_ready    (umi_in_ready),
    .umi_out_valid   (umi_out_valid),
    .umi_out_cmd     (umi_out_cmd),
    .umi_out_dstaddr (umi_out_dstaddr),
    .umi_out_srcaddr (umi_out_srcaddr),
    .umi_out_data    (umi_out_data),
    .umi_out_ready   (umi_out_ready),
    .lock_err        (lock_err)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           fails  = 0;
  int           cyc    = 0;
  beat_t        srcq [N][$];
  beat_t        expq [$];
  ev_t          out_log [$];
  ev_t          acc_log [$];
  logic [N-1:0] src_en;
  logic [N-1:0] rdy_hist [HIST];
  beat_t        out_hist [HIST];
  bit           model_locked;
  int           model_owner;
  int           model_idle;
  bit           exp_err;

  task automatic make_msg(input int ch, input int len);
    beat_t b;
    for (int k = 1; k <= len; k++) begin
      b = {CW'($urandom), AW'({$urandom, $urandom}), AW'({$urandom, $urandom}), DW'({$urandom, $urandom})};
      b[EOMB]  = (k == len);
      b[7:0]   = 8'(k);
      b[15:8]  = 8'(ch);
      srcq[ch].push_back(b);
    end
  endtask

  task automatic drive_inputs();
    beat_t b;
    for (int ch = 0; ch < N; ch++) begin
      if (src_en[ch] && srcq[ch].size() > 0) begin
        b = srcq[ch][0];
        umi_in_valid[ch]             = 1'b1;
        umi_in_cmd[ch*CW +: CW]      = b[BW-1 -: CW];
        umi_in_dstaddr[ch*AW +: AW]  = b[DW+2*AW-1 -: AW];
        umi_in_srcaddr[ch*AW +: AW]  = b[DW+AW-1 -: AW];
        umi_in_data[ch*DW +: DW]     = b[DW-1:0];
      end else begin
        umi_in_valid[ch]             = 1'b0;
        umi_in_cmd[ch*CW +: CW]      = '0;
        umi_in_dstaddr[ch*AW +: AW]  = '0;
        umi_in_srcaddr[ch*AW +: AW]  = '0;
        umi_in_data[ch*DW +: DW]     = '0;
      end
    end
  endtask

  // One clock: present inputs, check the DUT against the model mid-cycle, advance the model.
  task automatic step();
    logic [N-1:0] v, rdy, elig, exp_rdy;
    beat_t        b, outb;
    bit           space, legal;
    int           fi;
    drive_inputs();
    @(negedge clk);
    v     = umi_in_valid;
    rdy   = umi_in_ready;
    elig  = v & ~arb_mask;
    space = (expq.size() < 2);
    outb  = {umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data};
    if (cyc < HIST) begin
      rdy_hist[cyc] = rdy;
      out_hist[cyc] = outb;
    end
    checks++;
    if (model_locked) begin
      exp_rdy = space ? (N'(1) << model_owner) : '0;
      if (rdy !== exp_rdy) begin
        fails++;
        $display("FAIL ready_locked cyc=%0d got=%b want=%b", cyc, rdy, exp_rdy);
      end
    end else if (arb_mode == 2'b00) begin
      fi = -1;
      for (int i = N-1; i >= 0; i--) if (elig[i]) fi = i;
      exp_rdy = (space && fi >= 0) ? (N'(1) << fi) : '0;
      if (rdy !== exp_rdy) begin
        fails++;
        $display("FAIL ready_priority cyc=%0d got=%b want=%b", cyc, rdy, exp_rdy);
      end
    end else begin
      legal = ($countones(rdy) <= 1) && ((rdy & ~elig) == '0) && ((rdy != '0) == (space && elig != '0));
      if (!legal) begin
        fails++;
        $display("FAIL ready_fair cyc=%0d got=%b valid_unmasked=%b space=%0d", cyc, rdy, elig, space);
      end
    end
    checks++;
    if (umi_out_valid !== (expq.size() > 0)) begin
      fails++;
      $display("FAIL out_valid cyc=%0d got=%b want=%0d", cyc, umi_out_valid, expq.size() > 0);
    end
    if (expq.size() > 0) begin
      checks++;
      if (outb !== expq[0]) begin
        fails++;
        $display("FAIL out_beat cyc=%0d got cmd=%h tag=%h want cmd=%h tag=%h", cyc,
                 umi_out_cmd, umi_out_data[15:0], expq[0][BW-1 -: CW], expq[0][15:0]);
      end
    end
    checks++;
    if (lock_err !== exp_err) begin
      fails++;
      $display("FAIL lock_err cyc=%0d got=%b want=%b", cyc, lock_err, exp_err);
    end
    if (LOCKMON) begin
      if (model_locked && !v[model_owner]) begin
        if (model_idle < LT) model_idle++;
      end else begin
        model_idle = 0;
      end
      if (model_idle == LT) exp_err = 1'b1;
    end
    if (expq.size() > 0 && umi_out_ready) begin
      b = expq.pop_front();
      out_log.push_back('{cyc, int'(b[15:8]), int'(b[7:0]), b[EOMB]});
    end
    for (int ch = 0; ch < N; ch++) begin
      if (v[ch] && rdy[ch] && srcq[ch].size() > 0) begin
        b = srcq[ch].pop_front();
        expq.push_back(b);
        acc_log.push_back('{cyc, ch, int'(b[7:0]), b[EOMB]});
        if (!model_locked && !b[EOMB]) begin
          model_locked = 1'b1;
          model_owner  = ch;
        end else if (model_locked && b[EOMB]) begin
          model_locked = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int ch = 0; ch < N; ch++) srcq[ch].delete();
    expq.delete();
    out_log.delete();
    acc_log.delete();
    model_locked  = 1'b0;
    model_owner   = 0;
    model_idle    = 0;
    exp_err       = 1'b0;
    src_en        = '1;
    arb_mask      = '0;
    arb_mode      = 2'b00;
    umi_out_ready = 1'b1;
    drive_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset_state();
    reset = 1'b1;
    src_en = '1;
    arb_mask = '0;
    arb_mode = 2'b00;
    umi_out_ready = 1'b1;
    for (int ch = 0; ch < N; ch++) make_msg(ch, 1);
    drive_inputs();
    @(posedge clk);
    #1;
    checks++;
    if (umi_in_ready !== '0 || umi_out_valid !== 1'b0 || lock_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl got ready=%b valid=%b err=%b want 0", umi_in_ready, umi_out_valid, lock_err);
    end
    checks++;
    if ({umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data} !== '0) begin
      fails++;
      $display("FAIL reset_data got cmd=%h data=%h want 0", umi_out_cmd, umi_out_data[31:0]);
    end
    do_reset();
  endtask

  task automatic test_priority();
    int want_ch [6] = '{0, 0, 0, 2, 2, 2};
    int want_ix [6] = '{1, 2, 3, 1, 2, 3};
    do_reset();
    make_msg(0, 3);
    make_msg(2, 3);
    repeat (10) step();
    checks++;
    if (out_log.size() != 6) begin
      fails++;
      $display("FAIL prio_count got=%0d want=6", out_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (out_log[i].cyc != i+1 || out_log[i].ch != want_ch[i] || out_log[i].idx != want_ix[i]) begin
          fails++;
          $display("FAIL prio_order[%0d] got cyc=%0d ch=%0d idx=%0d want cyc=%0d ch=%0d idx=%0d", i,
                   out_log[i].cyc, out_log[i].ch, out_log[i].idx, i+1, want_ch[i], want_ix[i]);
        end
      end
    end
    checks++;
    if (rdy_hist[0][2] || rdy_hist[1][2] || rdy_hist[2][2]) begin
      fails++;
      $display("FAIL prio_ch2_stall got ready2=%b%b%b want 000", rdy_hist[0][2], rdy_hist[1][2], rdy_hist[2][2]);
    end
  endtask

  task automatic test_roundrobin();
    int per_ch [N];
    int bad_cyc;
    logic [N-1:0] seen;
    do_reset();
    arb_mode = 2'b01;
    for (int ch = 0; ch < N; ch++) begin
      per_ch[ch] = 0;
      for (int m = 0; m < 6; m++) make_msg(ch, 1);
    end
    repeat (28) step();
    bad_cyc = 0;
    seen = '0;
    foreach (out_log[i]) begin
      if (out_log[i].cyc != i+1) bad_cyc++;
      per_ch[out_log[i].ch]++;
      if (i < 8) seen[out_log[i].ch] = 1'b1;
    end
    checks++;
    if (out_log.size() != 24 || bad_cyc != 0) begin
      fails++;
      $display("FAIL rr_throughput got beats=%0d gaps=%0d want beats=24 gaps=0", out_log.size(), bad_cyc);
    end
    checks++;
    if (seen !== '1) begin
      fails++;
      $display("FAIL rr_fair_first8 got served=%b want=1111", seen);
    end
    for (int ch = 0; ch < N; ch++) begin
      checks++;
      if (per_ch[ch] != 6) begin
        fails++;
        $display("FAIL rr_served ch=%0d got=%0d want=6", ch, per_ch[ch]);
      end
    end
  endtask

  task automatic test_backpressure();
    beat_t bp [$];
    int    bad;
    do_reset();
    make_msg(1, 5);
    bp = srcq[1];
    for (int c = 0; c < 14; c++) begin
      umi_out_ready = !(c >= 2 && c <= 6);
      step();
    end
    checks++;
    if (rdy_hist[3][1] !== 1'b0 || rdy_hist[6][1] !== 1'b0) begin
      fails++;
      $display("FAIL bp_stall got ready1@3=%b ready1@6=%b want 0", rdy_hist[3][1], rdy_hist[6][1]);
    end
    bad = 0;
    for (int c = 2; c <= 6; c++) if (out_hist[c] !== bp[1]) bad++;
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL bp_head_stable got %0d unstable cycles want 0", bad);
    end
    bad = 0;
    foreach (out_log[i]) if (out_log[i].idx != i+1 || out_log[i].ch != 1) bad++;
    checks++;
    if (out_log.size() != 5 || bad != 0) begin
      fails++;
      $display("FAIL bp_delivery got beats=%0d misordered=%0d want beats=5 misordered=0", out_log.size(), bad);
    end
  endtask

  task automatic test_lock_hold();
    int eom_cyc, ch0_cyc, bad;
    do_reset();
    make_msg(3, 2);
    make_msg(0, 1);
    for (int c = 0; c < 16; c++) begin
      src_en   = (c == 0) ? 4'b1000 : (c <= 10) ? 4'b0001 : 4'b1001;
      arb_mask = (c >= 5) ? 4'b1000 : 4'b0000;
      step();
    end
    eom_cyc = -1;
    ch0_cyc = -1;
    foreach (acc_log[i]) begin
      if (acc_log[i].ch == 3 && acc_log[i].eom) eom_cyc = acc_log[i].cyc;
      if (acc_log[i].ch == 0) ch0_cyc = acc_log[i].cyc;
    end
    checks++;
    if (eom_cyc != 11) begin
      fails++;
      $display("FAIL lock_eom_accept got cyc=%0d want=11", eom_cyc);
    end
    checks++;
    if (ch0_cyc != 12) begin
      fails++;
      $display("FAIL lock_ch0_grant got cyc=%0d want=12", ch0_cyc);
    end
    bad = 0;
    for (int c = 1; c <= 11; c++) if (rdy_hist[c][0]) bad++;
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL lock_ch0_stall got %0d ready cycles want 0", bad);
    end
  endtask

  task automatic test_reset_midmsg();
    do_reset();
    make_msg(1, 4);
    step();
    drive_inputs();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (umi_out_valid !== 1'b0 || umi_in_ready !== '0 || lock_err !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_ctrl got valid=%b ready=%b err=%b want 0", umi_out_valid, umi_in_ready, lock_err);
    end
    checks++;
    if ({umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data} !== '0) begin
      fails++;
      $display("FAIL rst_mid_data got cmd=%h data=%h want 0", umi_out_cmd, umi_out_data[31:0]);
    end
    do_reset();
    make_msg(2, 2);
    repeat (5) step();
    checks++;
    if (out_log.size() != 2 || out_log[0].ch != 2 || out_log[0].cyc != 1 || out_log[1].idx != 2 || out_log[1].cyc != 2) begin
      fails++;
      $display("FAIL rst_new_msg got beats=%0d want 2 beats of ch2 at cycles 1-2", out_log.size());
    end
  endtask

  task automatic test_random();
    int budget, pending, total, bad;
    for (int m = 0; m < 3; m++) begin
      do_reset();
      arb_mode = 2'(m);
      arb_mask = 4'($urandom_range(0, 14));
      total = 0;
      for (int ch = 0; ch < N; ch++) begin
        for (int k = 0; k < 4; k++) begin
          make_msg(ch, $urandom_range(1, 4));
        end
        if (!arb_mask[ch]) total += srcq[ch].size();
      end
      for (int c = 0; c < 120; c++) begin
        src_en        = 4'($urandom);
        umi_out_ready = ($urandom_range(0, 9) < 7);
        step();
      end
      src_en        = '1;
      umi_out_ready = 1'b1;
      budget        = 0;
      pending       = 1;
      while (pending > 0 && budget < 300) begin
        pending = expq.size();
        for (int ch = 0; ch < N; ch++) if (!arb_mask[ch]) pending += srcq[ch].size();
        if (pending > 0) begin
          step();
          budget++;
        end
      end
      checks++;
      if (budget >= 300) begin
        fails++;
        $display("FAIL rand_drain mode=%0d got pending=%0d after %0d cycles want 0", m, pending, budget);
      end
      checks++;
      if (out_log.size() != total) begin
        fails++;
        $display("FAIL rand_count mode=%0d got=%0d want=%0d", m, out_log.size(), total);
      end
      bad = 0;
      for (int i = 1; i < out_log.size(); i++)
        if (!out_log[i-1].eom && out_log[i].ch != out_log[i-1].ch) bad++;
      checks++;
      if (bad != 0) begin
        fails++;
        $display("FAIL rand_interleave mode=%0d got %0d violations want 0", m, bad);
      end
    end
  endtask

  task automatic test_lockmon();
    do_reset();
    make_msg(2, 2);
    for (int c = 0; c < 9; c++) begin
      src_en = (c == 0) ? 4'b0100 : 4'b0000;
      step();
    end
    checks++;
    if (lock_err !== LOCKMON) begin
      fails++;
      $display("FAIL lockmon_set got=%b want=%b", lock_err, LOCKMON);
    end
    src_en = 4'b0100;
    repeat (3) step();
    checks++;
    if (lock_err !== LOCKMON) begin
      fails++;
      $display("FAIL lockmon_sticky got=%b want=%b", lock_err, LOCKMON);
    end
    checks++;
    if (out_log.size() != 2) begin
      fails++;
      $display("FAIL lockmon_flow got beats=%0d want=2", out_log.size());
    end
    reset = 1'b1;
    #1;
    checks++;
    if (lock_err !== 1'b0) begin
      fails++;
      $display("FAIL lockmon_clear got=%b want=0", lock_err);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    arb_mode       = 2'b00;
    arb_mask       = '0;
    umi_in_valid   = '0;
    umi_in_cmd     = '0;
    umi_in_dstaddr = '0;
    umi_in_srcaddr = '0;
    umi_in_data    = '0;
    umi_out_ready  = 1'b1;
    src_en         = '1;
    test_reset_state();
    test_priority();
    test_roundrobin();
    test_backpressure();
    test_lock_hold();
    test_reset_midmsg();
    test_random();
    test_lockmon();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
